// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    // Controller states: wait for a request, shift one bit per cycle, report.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operand/result width used when the parent does not override WIDTH.
    localparam int SUB_DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow into the next bit.
// Purely combinational; the serial controller owns all state.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for a single bit position.
    // NOTE: every output is assigned on every pass through the block, so no
    // latch can be inferred; keep it that way when editing combinational code.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~x & bin) | (y & bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor computing diff = a - b (mod 2^WIDTH), one bit
// per clock, LSB first. A request is taken only in IDLE; the operands are
// captured then, so later changes on a/b have no effect. Results appear only
// once the whole word is done and hold until the next completion.
//
// Timing for a start accepted at edge N:
//   edges N+1 .. N+WIDTH  process bits 0 .. WIDTH-1 (state SHIFT)
//   edge  N+WIDTH         loads diff/borrow_out and enters DONE
//   edge  N+WIDTH+1       returns to IDLE and raises the one-cycle done pulse
// A continuously held start therefore repeats every WIDTH+2 cycles.
//
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the overflow output
// (two's-complement overflow of a - b, loaded and held alongside diff).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;      // minuend, shifted right as bits are consumed
    logic [WIDTH-1:0] b_sh;      // subtrahend, shifted right as bits are consumed
    logic [WIDTH-1:0] res_sh;    // result bits enter at the MSB and move down
    logic [WIDTH-1:0] res_next;
    logic             br;        // borrow carried between bit positions
    logic [CNT_W-1:0] cnt;       // bits processed so far in this operation
    logic             fs_d;
    logic             fs_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Sign bits of the captured operands; the shift registers lose them.
    logic             a_msb;
    logic             b_msb;
`endif

    // The pre-shift LSB falls off the end on each shift and is never needed.
    logic unused_res_lsb;
    assign unused_res_lsb = res_sh[0];

    // Result register after the current bit has been shifted in at the top.
    assign res_next = {fs_d, res_sh[WIDTH-1:1]};

    // Single shared bit slice fed by the low bits of the operand registers.
    full_subtractor u_bit (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (br),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Controller, datapath registers and registered outputs.
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register here samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are cleared on reset as well, so an
            // aborted operation leaves no stale operand or partial result.
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end

                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= fs_bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Last bit: publish the complete word in one step.
                        diff       <= res_next;
                        borrow_out <= fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        overflow   <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
                        state      <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
// Define SERIAL_SUB_OVERFLOW_EN to also check the overflow output.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] prev_diff;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE (called just after a falling edge) and
    // check latency, operand capture, result hold and final values.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                         input string tag);
        int lat;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                a     = ~av;
                b     = ~bv;
                check({tag, "_busy"}, 32'(busy), 32'd1);
            end
            if (k == 4) check({tag, "_hold"}, 32'(diff), 32'(prev_diff));
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        if (lat >= 0) begin
            check({tag, "_diff"}, 32'(diff), 32'(ed));
            check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
            check({tag, "_busy_end"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
            check({tag, "_ovf"}, 32'(overflow), 32'(eo));
`else
            if (eo === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
        end
        prev_diff = ed;
    endtask

    initial begin
        int lat;
        int n_done;
        int n_busy;
        int pulses;
        int last_k;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        prev_diff = '0;

        // Reset state, with start requested during reset.
        repeat (3) @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst = 1'b0;

        // Basic subtraction, sign-crossing result, overflow case.
        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub_05_03");
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_03_05");
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");
        repeat (3) @(negedge clk);
        check("idle_hold_diff", 32'(diff), 32'h7F);

        // Start pulse during SHIFT must be ignored.
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        lat    = -1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 2) begin
                a     = 8'hFF;
                b     = 8'h00;
                start = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("busy_start_latency", 32'(lat), 32'd9);
        check("busy_start_diff", 32'(diff), 32'h0F);
        check("busy_start_borrow", 32'(borrow_out), 32'd0);
        n_busy = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) n_done++;
        end
        check("busy_start_no_second_busy", 32'(n_busy), 32'd0);
        check("busy_start_no_second_done", 32'(n_done), 32'd0);

        // Reset in the 4th SHIFT cycle aborts the operation.
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        rst = 1'b0;
        prev_diff = '0;
        // Started in the first cycle after reset deasserts; a stray done from
        // the aborted operation would show up as a short latency.
        do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "sub_00_ff");

        // Held start: back-to-back a == b operations every 10 cycles.
        a      = 8'h5A;
        b      = 8'h5A;
        start  = 1'b1;
        @(posedge clk);
        pulses = 0;
        last_k = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("b2b_diff", 32'(diff), 32'h00);
                check("b2b_borrow", 32'(borrow_out), 32'd0);
                if (last_k < 0) check("b2b_first", 32'(k), 32'd9);
                else            check("b2b_period", 32'(k - last_k), 32'd10);
                last_k = k;
            end
        end
        start = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, synchronous to clk, active-high.
REQ-004 Port: start  input  1  request to compute a - b; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 Port: busy  output  1  high while in SHIFT or DONE.
REQ-008 Port: done  output  1  one-cycle pulse when diff/borrow_out are valid.
REQ-009 Port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 Port: borrow_out  output  1  high when unsigned a < b.
REQ-011 Port (macro only): overflow  output  1  two's-complement overflow of a - b.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL load a and b into shift registers, clear the borrow flop and bit counter, and move to SHIFT; start=0 stays in IDLE.
REQ-014 SHIFT SHALL process one bit per cycle, LSB first: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~ai & br) | (bi & br).
REQ-015 Each SHIFT cycle SHALL shift d into the result register MSB, with the result register shifting right, so that after WIDTH cycles bit 0 holds the first computed bit.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of clog2(WIDTH+1) bits, then move to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge N means done=1 in the cycle after edge N+WIDTH+1 (WIDTH+1 cycles after acceptance).
REQ-019 diff and borrow_out SHALL update only on the DONE entry edge and hold until the next DONE; they SHALL NOT show partial results.
REQ-020 start while busy=1 (SHIFT or DONE) SHALL be ignored; a, b changes after acceptance SHALL NOT affect the result.
REQ-021 start held high continuously SHALL produce back-to-back operations, one every WIDTH+2 cycles.
REQ-022 Boundary: a == b SHALL give diff=0 and borrow_out=0; a=0, b=2^WIDTH-1 SHALL give diff=1 and borrow_out=1.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0 (if present), and clear the counter, borrow flop, and shift registers.
REQ-024 rst SHALL take priority over start and over any in-progress SHIFT; an aborted operation SHALL produce no done pulse.
REQ-025 The first start SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-026 Macro SERIAL_SUB_OVERFLOW_EN: when defined, port overflow exists and SHALL be set on the DONE entry edge to (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands, and held like diff.
REQ-027 When SERIAL_SUB_OVERFLOW_EN is undefined, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package serial_sub_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and the default-width constant.
REQ-029 The single-bit difference/borrow logic SHALL be a sub-module named full_subtractor (inputs x, y, bin; outputs d, bout), instantiated once.
REQ-030 full_subtractor SHALL be purely combinational; all state SHALL reside in serial_subtractor.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, pulse start -> done at 9 cycles after acceptance; diff=0x02, borrow_out=0.
REQ-032 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; with macro, overflow=0.
REQ-033 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0; with macro, overflow=1.
REQ-034 Start accepted with a=0x10, b=0x01; during SHIFT, pulse start with a=0xFF, b=0x00 -> single done with diff=0x0F; no second operation begins.
REQ-035 Assert rst during the 4th SHIFT cycle -> next cycle has busy=0, diff=0, and no done pulse; a following start with a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
REQ-036 Hold start=1 for 30 cycles with a=b=0x5A -> done pulses every 10 cycles, each with diff=0x00, borrow_out=0.
